// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : divider_pkg
//  Description : Shared types and constants for the iterative 64-bit divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package divider_pkg;

    localparam int DIV_WIDTH    = 64;
    localparam int DIV_CNT_BITS = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage : divider_pkg
`default_nettype wire

// File: rtl/ripple_carry_adder_64.sv
`default_nettype none
// ============================================================================
//  Module      : ripple_carry_adder_64
//  Description : Gate-level ripple-carry adder/subtractor. With sub = 1 it
//                computes a - b and carry_out is the no-borrow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module ripple_carry_adder_64
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_b_eff;

    // Subtraction is a + ~b + 1: invert b and inject the +1 as carry-in.
    assign w_carry[0] = sub;

    // One full adder per bit; carries ripple from LSB to MSB.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign w_b_eff[i]   = b[i] ^ sub;
        assign sum[i]       = a[i] ^ w_b_eff[i] ^ w_carry[i];
        assign w_carry[i+1] = (a[i] & w_b_eff[i]) | (w_carry[i] & (a[i] ^ w_b_eff[i]));
    end : g_bit

    assign carry_out = w_carry[WIDTH];
    assign overflow  = w_carry[WIDTH] ^ w_carry[WIDTH-1];

endmodule : ripple_carry_adder_64
`default_nettype wire

// File: rtl/seq_divider_64.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider_64
//  Description : Iterative restoring shift-subtract divider, one quotient
//                bit per clock, for UDIV/SDIV with start/busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divider_64
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_t              r_state;
    div_state_t              w_next_state;
    logic [DIV_CNT_BITS-1:0] r_cnt;
    logic [WIDTH-1:0]        r_rem;
    logic [WIDTH-1:0]        r_q;
    logic [WIDTH-1:0]        r_dvs_mag;
    logic                    r_neg_q;
    logic                    r_neg_r;
    logic                    r_dbz;
    logic [WIDTH-1:0]        r_quot_out;
    logic [WIDTH-1:0]        r_rem_out;
    logic                    r_dbz_out;

    logic                    w_div_zero;
    logic                    w_dvd_neg;
    logic                    w_dvs_neg;
    logic [WIDTH-1:0]        w_dvd_mag;
    logic [WIDTH-1:0]        w_dvs_mag;
    logic [WIDTH-1:0]        w_r_shifted;
    logic                    w_msb_out;
    logic [WIDTH-1:0]        w_trial;
    logic                    w_no_borrow;
    logic                    w_unused_overflow;
    logic                    w_take;
    logic                    w_last;
    logic [WIDTH-1:0]        w_quot_final;
    logic [WIDTH-1:0]        w_rem_final;

    assign w_div_zero  = (divisor == '0);
    assign w_dvd_neg   = is_signed & dividend[WIDTH-1];
    assign w_dvs_neg   = is_signed & divisor[WIDTH-1];
    assign w_dvd_mag   = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_mag   = w_dvs_neg ? -divisor  : divisor;

    // {R,Q} shifted left by one; the bit leaving R is kept as msb_out so a
    // shifted value that overflows WIDTH bits still counts as >= divisor.
    assign w_msb_out   = r_rem[WIDTH-1];
    assign w_r_shifted = {r_rem[WIDTH-2:0], r_q[WIDTH-1]};
    assign w_take      = w_msb_out | w_no_borrow;
    assign w_last      = (r_cnt == DIV_CNT_BITS'(WIDTH - 1));

    assign w_quot_final = r_neg_q ? -r_q   : r_q;
    assign w_rem_final  = r_neg_r ? -r_rem : r_rem;

    ripple_carry_adder_64 #(
        .WIDTH     (WIDTH)
    ) u_trial_sub (
        .a         (w_r_shifted),
        .b         (r_dvs_mag),
        .sub       (1'b1),
        .sum       (w_trial),
        .carry_out (w_no_borrow),
        .overflow  (w_unused_overflow)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: IDLE -> RUN -> DONE -> IDLE, or IDLE -> DONE on /0.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = w_div_zero ? DONE : RUN;
            RUN:     if (w_last) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath: operand capture, one shift-subtract step per RUN cycle,
    // result registration in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_rem      <= '0;
            r_q        <= '0;
            r_dvs_mag  <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dbz      <= 1'b0;
            r_quot_out <= '0;
            r_rem_out  <= '0;
            r_dbz_out  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cnt      <= '0;
                        r_quot_out <= '0;
                        r_rem_out  <= '0;
                        r_dbz_out  <= 1'b0;
                        if (w_div_zero) begin
                            // Feed the raw dividend through the DONE stage as
                            // the remainder with no sign fix-up.
                            r_q       <= '0;
                            r_rem     <= dividend;
                            r_dvs_mag <= '0;
                            r_neg_q   <= 1'b0;
                            r_neg_r   <= 1'b0;
                            r_dbz     <= 1'b1;
                        end else begin
                            r_q       <= w_dvd_mag;
                            r_rem     <= '0;
                            r_dvs_mag <= w_dvs_mag;
                            r_neg_q   <= w_dvd_neg ^ w_dvs_neg;
                            r_neg_r   <= w_dvd_neg;
                            r_dbz     <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    r_rem <= w_take ? w_trial : w_r_shifted;
                    r_q   <= {r_q[WIDTH-2:0], w_take};
                    r_cnt <= r_cnt + DIV_CNT_BITS'(1);
                end
                DONE: begin
                    r_quot_out <= w_quot_final;
                    r_rem_out  <= w_rem_final;
                    r_dbz_out  <= r_dbz;
                end
                default: begin
                end
            endcase
        end
    end

    // Results are presented directly in the DONE cycle, then held from regs.
    always_comb begin
        busy        = (r_state != IDLE);
        done        = (r_state == DONE);
        quotient    = done ? w_quot_final : r_quot_out;
        remainder   = done ? w_rem_final  : r_rem_out;
        div_by_zero = done ? r_dbz        : r_dbz_out;
    end

endmodule : seq_divider_64
`default_nettype wire

// File: tb/tb_seq_divider_64.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_divider_64
//  Description : Self-checking bench for seq_divider_64 with an arithmetic
//                reference model, directed corner cases and random operands.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider_64;
    import divider_pkg::*;

    localparam int W = DIV_WIDTH;
    localparam logic [W-1:0] C_MIN  = 64'h8000_0000_0000_0000;
    localparam logic [W-1:0] C_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int tests = 0;
    int fails = 0;

    seq_divider_64 #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #1000 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division semantics.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        sa = a;
        sb = b;
        z  = 1'b0;
        if (b == '0) begin
            q = '0; r = a; z = 1'b1;
        end else if (!s) begin
            q = a / b; r = a % b;
        end else if (a == C_MIN && b == C_ONES) begin
            q = C_MIN; r = '0;
        end else begin
            q = sa / sb; r = sa % sb;
        end
    endtask

    // Called at the negedge of cycle 1; returns the cycle number done rose in.
    task automatic wait_done(output int lat, output bit busy_ok);
        lat     = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && lat < 200) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (busy !== 1'b1) busy_ok = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s);
        logic [W-1:0] eq, er;
        logic         ez;
        int           lat;
        bit           bok;
        model(a, b, s, eq, er, ez);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b; is_signed = s;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bok);
        chk({tag, " latency"}, W'(lat), (b == '0) ? W'(1) : W'(W + 1));
        chk({tag, " busy"}, W'(bok), W'(1));
        chk({tag, " quotient"}, quotient, eq);
        chk({tag, " remainder"}, remainder, er);
        chk({tag, " dbz"}, W'(div_by_zero), W'(ez));
        @(negedge clk);
        chk({tag, " idle"}, W'({busy, done}), W'(0));
        chk({tag, " held q"}, quotient, eq);
        chk({tag, " held r"}, remainder, er);
    endtask

    initial begin
        logic [W-1:0] a, b, eq, er, eq2, er2;
        logic         s, ez;
        int           lat;
        bit           bok;
        bit           saw_done;

        reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        chk("rst busy", W'(busy), W'(0));
        chk("rst done", W'(done), W'(0));
        chk("rst q", quotient, '0);
        chk("rst r", remainder, '0);
        chk("rst dbz", W'(div_by_zero), W'(0));
        reset = 1'b0;

        run_op("u100/7", 64'd100, 64'd7, 1'b0);
        run_op("s-100/7", -64'sd100, 64'd7, 1'b1);
        run_op("s100/-7", 64'd100, -64'sd7, 1'b1);
        run_op("uones/1", C_ONES, 64'd1, 1'b0);
        run_op("smin/-1", C_MIN, C_ONES, 1'b1);
        run_op("u55/0", 64'd55, 64'd0, 1'b0);
        run_op("s-9/0", -64'sd9, 64'd0, 1'b1);
        run_op("umin/-1", C_MIN, C_ONES, 1'b0);

        for (int i = 0; i < 16; i++) begin
            a = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       b = {$urandom, $urandom};
                1:       b = W'($urandom_range(1, 1000));
                2:       b = W'($urandom);
                default: b = -W'($urandom_range(1, 1000));
            endcase
            if ($urandom_range(0, 9) == 0) b = '0;
            s = 1'(($urandom >> 3) & 1);
            run_op($sformatf("rand%0d", i), a, b, s);
        end

        // Start held high across a whole run with fresh operands.
        model(64'd1000, 64'd9, 1'b0, eq, er, ez);
        model(-64'sd50, 64'd4, 1'b1, eq2, er2, ez);
        @(negedge clk);
        start = 1'b1; dividend = 64'd1000; divisor = 64'd9; is_signed = 1'b0;
        @(negedge clk);
        dividend = -64'sd50; divisor = 64'd4; is_signed = 1'b1;
        wait_done(lat, bok);
        chk("hs first latency", W'(lat), W'(W + 1));
        chk("hs first q", quotient, eq);
        chk("hs first r", remainder, er);
        @(negedge clk);
        chk("hs idle gap", W'({busy, done}), W'(0));
        chk("hs held q", quotient, eq);
        @(negedge clk);
        chk("hs second accepted", W'(busy), W'(1));
        chk("hs cleared q", quotient, '0);
        start = 1'b0;
        wait_done(lat, bok);
        chk("hs second latency", W'(lat), W'(W + 1));
        chk("hs second q", quotient, eq2);
        chk("hs second r", remainder, er2);

        // Reset in the middle of a run.
        @(negedge clk);
        start = 1'b1; dividend = 64'd1000; divisor = 64'd3; is_signed = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid rst busy", W'(busy), W'(0));
        chk("mid rst done", W'(done), W'(0));
        chk("mid rst q", quotient, '0);
        chk("mid rst r", remainder, '0);
        chk("mid rst dbz", W'(div_by_zero), W'(0));
        saw_done = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        chk("mid rst no activity", W'(saw_done), W'(0));
        run_op("u9/3", 64'd9, 64'd3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_seq_divider_64
`default_nettype wire
